subsurf_face_avg: RTL and testbench

- Catmull-Clark face-point stage of the subdivision-surface ASIC.
- On `start`, reads a quad-face list and vertex table from two external 512x32 single-port SRAMs (DFFRAM-style).
- Averages the four corner vertices of every face and writes each face point to a third SRAM.
- `busy` flags the run to the host.

---
 rtl/subsurf_face_avg_if.sv | 24 ++
 rtl/subsurf_face_avg.sv | 154 +++++++++++++++
 tb/tb_subsurf_face_avg.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/subsurf_face_avg_if.sv
// RAM-port bundle for the face-point stage: host start/busy plus three 512x32 SRAM ports.
// The master side is the averaging engine; the slave side is the host and the SRAMs.
interface subsurf_face_avg_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start;
  logic                  busy;
  logic                  en0, en1, en2;
  logic [ADDR_WIDTH-1:0] a0, a1, a2;
  logic [3:0]            we0, we1, we2;
  logic [DATA_WIDTH-1:0] di0, di1, di2;
  logic [DATA_WIDTH-1:0] do0, do1, do2;

  modport master (
    input  start, do0, do1, do2,
    output busy, en0, en1, en2, a0, a1, a2, we0, we1, we2, di0, di1, di2
  );

  modport slave (
    output start, do0, do1, do2,
    input  busy, en0, en1, en2, a0, a1, a2, we0, we1, we2, di0, di1, di2
  );
endinterface

// File: rtl/subsurf_face_avg.sv
// Catmull-Clark face-point stage: reads quad faces from RAM1, averages the four corner
// vertices fetched from RAM0 and writes one packed face point per face to RAM2.
module subsurf_face_avg #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned COORD_W    = 10
) (
  input  logic               clk,
  input  logic               rst,
  subsurf_face_avg_if.master ram_io
);

  localparam int unsigned SumW = COORD_W + 2;
  localparam int unsigned IdxW = 8;

  typedef enum logic [3:0] {
    StIdle, StCntRd, StCntCap, StFaceRd, StFaceCap, StV0, StV1, StV2, StV3, StWr
  } state_e;

  state_e                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      n_q, n_d;
  logic [ADDR_WIDTH-1:0]      i_q, i_d;
  logic [3:0][IdxW-1:0]       idx_q, idx_d;
  logic [2:0][SumW-1:0]       acc_q, acc_d;

  logic [2:0][SumW-1:0]       vtx, sum;
  logic [2:0][COORD_W-1:0]    avg;
  logic [ADDR_WIDTH-1:0]      i_inc;

  logic                       en0, en1, en2;
  logic [ADDR_WIDTH-1:0]      a0, a1, a2;
  logic [3:0]                 we2;
  logic [DATA_WIDTH-1:0]      di2;

  // Sign-extend the returned vertex and add it to the running per-axis sums; the
  // arithmetic shift by two is just dropping the two low bits of the 12-bit sum.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      vtx[k] = {{(SumW - COORD_W){ram_io.do0[k*COORD_W + COORD_W - 1]}},
                ram_io.do0[k*COORD_W +: COORD_W]};
      sum[k] = acc_q[k] + vtx[k];
      avg[k] = sum[k][SumW-1:2];
    end
  end

  assign i_inc = i_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    en0     = 1'b0;
    en1     = 1'b0;
    en2     = 1'b0;
    a0      = '0;
    a1      = '0;
    a2      = '0;
    we2     = '0;
    di2     = '0;
    unique case (state_q)
      StIdle: begin
        if (ram_io.start) state_d = StCntRd;
      end
      StCntRd: begin
        en1     = 1'b1;
        state_d = StCntCap;
      end
      StCntCap: begin
        n_d     = ram_io.do1[ADDR_WIDTH-1:0];
        i_d     = '0;
        state_d = (ram_io.do1[ADDR_WIDTH-1:0] == '0) ? StIdle : StFaceRd;
      end
      StFaceRd: begin
        en1     = 1'b1;
        a1      = i_inc;
        state_d = StFaceCap;
      end
      StFaceCap: begin
        for (int k = 0; k < 4; k++) idx_d[k] = ram_io.do1[k*IdxW +: IdxW];
        state_d = StV0;
      end
      StV0: begin
        en0     = 1'b1;
        a0      = ADDR_WIDTH'(idx_q[0]);
        acc_d   = '0;
        state_d = StV1;
      end
      StV1: begin
        en0     = 1'b1;
        a0      = ADDR_WIDTH'(idx_q[1]);
        acc_d   = sum;
        state_d = StV2;
      end
      StV2: begin
        en0     = 1'b1;
        a0      = ADDR_WIDTH'(idx_q[2]);
        acc_d   = sum;
        state_d = StV3;
      end
      StV3: begin
        en0     = 1'b1;
        a0      = ADDR_WIDTH'(idx_q[3]);
        acc_d   = sum;
        state_d = StWr;
      end
      StWr: begin
        en2     = 1'b1;
        we2     = 4'hF;
        a2      = i_q;
        di2     = DATA_WIDTH'(avg);
        i_d     = i_inc;
        state_d = (i_inc == n_q) ? StIdle : StFaceRd;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      n_q     <= '0;
      i_q     <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  assign ram_io.busy = (state_q != StIdle);
  assign ram_io.en0  = en0;
  assign ram_io.en1  = en1;
  assign ram_io.en2  = en2;
  assign ram_io.a0   = a0;
  assign ram_io.a1   = a1;
  assign ram_io.a2   = a2;
  assign ram_io.we0  = '0;
  assign ram_io.we1  = '0;
  assign ram_io.we2  = we2;
  assign ram_io.di0  = '0;
  assign ram_io.di1  = '0;
  assign ram_io.di2  = di2;

  // RAM2 is write-only and the vertex pad bits carry no data.
  logic unused_do;
  assign unused_do = ^{ram_io.do2, ram_io.do0[DATA_WIDTH-1:3*COORD_W]};

endmodule

// File: tb/tb_subsurf_face_avg.sv
// Self-checking bench for subsurf_face_avg: behavioural SRAMs, vector table, directed
// corner sequences and randomized runs checked against a plain-arithmetic model.
module tb_subsurf_face_avg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  subsurf_face_avg_if bus ();

  subsurf_face_avg dut (
    .clk    (clk),
    .rst    (rst),
    .ram_io (bus)
  );

  logic [31:0] ram0 [512];
  logic [31:0] ram1 [512];
  logic [31:0] ram2 [512];

  assign bus.do2 = '0;

  always @(posedge clk) begin
    if (bus.en0) bus.do0 <= ram0[bus.a0];
    if (bus.en1) bus.do1 <= ram1[bus.a1];
    if (bus.en2) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.we2[b]) ram2[bus.a2][8*b +: 8] <= bus.di2[8*b +: 8];
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int wr_cnt   = 0;
  int viol     = 0;
  logic [8:0] wr_log [1024];
  logic bad;

  assign bad = (bus.we0 != 0) || (bus.we1 != 0) || (bus.di0 != 0) || (bus.di1 != 0)
            || (!bus.en0 && bus.a0 != 0) || (!bus.en1 && bus.a1 != 0)
            || (!bus.en2 && (bus.a2 != 0 || bus.di2 != 0 || bus.we2 != 0))
            || (bus.en2 && (bus.we2 != 4'hF || bus.di2[31:30] != 2'b00))
            || (!bus.busy && (bus.en0 || bus.en1 || bus.en2));

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) busy_cnt <= busy_cnt + 1;
      if (bus.en2) begin
        wr_log[wr_cnt[9:0]] <= bus.a2;
        wr_cnt <= wr_cnt + 1;
      end
      if (bad) viol <= viol + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int x, input int y, input int z);
    logic [31:0] r;
    r = '0;
    r[9:0]   = x[9:0];
    r[19:10] = y[9:0];
    r[29:20] = z[9:0];
    return r;
  endfunction

  // Reference: per axis, sum the four signed corners and take floor(sum / 4).
  function automatic logic [31:0] model_face(input logic [31:0] face);
    logic [31:0] r, v;
    logic [9:0]  c;
    int s, q;
    r = '0;
    for (int ax = 0; ax < 3; ax++) begin
      s = 0;
      for (int k = 0; k < 4; k++) begin
        v = ram0[{1'b0, face[8*k +: 8]}];
        c = v[10*ax +: 10];
        s += c[9] ? int'(c) - 1024 : int'(c);
      end
      q = (s >= 0) ? s / 4 : -((3 - s) / 4);
      r[10*ax +: 10] = q[9:0];
    end
    return r;
  endfunction

  task automatic run(input int rp_a, input int rp_b, output int bc, output int wc,
                     output int w0);
    int b0, cyc;
    @(negedge clk); #1;
    b0 = busy_cnt;
    w0 = wr_cnt;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    cyc = 1;
    while (bus.busy && cyc < 4000) begin
      bus.start = (cyc == rp_a || cyc == rp_b);
      @(negedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    check("run_bounded", 32'(cyc < 4000), 32'd1);
    bc = busy_cnt - b0;
    wc = wr_cnt - w0;
  endtask

  typedef struct {
    logic [3:0][31:0] v;
    logic [31:0]      exp;
  } vec_t;

  vec_t        tbl [5];
  int          bc, wc, w0, n;
  logic [31:0] exp_q [$];

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_ctrl", 32'({bus.en0, bus.en1, bus.en2, bus.we0, bus.we1, bus.we2}), 32'd0);
    check("reset_addr", 32'({bus.a0, bus.a1, bus.a2}), 32'd0);
    check("reset_di2", bus.di2, 32'd0);
    rst = 1'b0;

    tbl[0].v = {pk(4, 12, 12), pk(8, 12, 12), pk(8, 8, 12), pk(4, 8, 12)};
    tbl[0].exp = 32'h00C0_2806;
    tbl[1].v = {pk(-2, 0, 0), pk(-1, 0, 0), pk(-1, 0, 0), pk(-1, 0, 0)};
    tbl[1].exp = 32'h0000_03FE;
    tbl[2].v = {4{pk(511, 511, 511)}};
    tbl[2].exp = 32'h1FF7_FDFF;
    tbl[3].v = {4{32'hC000_0000 | pk(-512, -512, -512)}};
    tbl[3].exp = 32'h2008_0200;
    tbl[4].v = {pk(0, -2, 103), pk(1, -3, 102), pk(1, -3, 101), pk(1, -3, 100)};
    tbl[4].exp = 32'h065F_F400;

    for (int t = 0; t < 5; t++) begin
      for (int k = 0; k < 4; k++) ram0[k] = tbl[t].v[k];
      ram1[0] = (t == 0) ? 32'h1 : 32'hABCD_E001;
      ram1[1] = 32'h0302_0100;
      run(0, 0, bc, wc, w0);
      check($sformatf("vec%0d_result", t), ram2[0], tbl[t].exp);
      check($sformatf("vec%0d_busy", t), 32'(bc), 32'd9);
      check($sformatf("vec%0d_writes", t), 32'(wc), 32'd1);
      check($sformatf("vec%0d_addr", t), 32'(wr_log[w0[9:0]]), 32'd0);
    end

    // Three faces sharing vertices, hand-computed averages.
    ram0[10] = pk(0, 0, 0);
    ram0[11] = pk(4, 4, 4);
    ram0[12] = pk(8, -4, 0);
    ram0[13] = pk(-4, 8, 20);
    ram1[0] = 32'd3;
    ram1[1] = 32'h0D0C_0B0A;
    ram1[2] = 32'h0C0C_0B0B;
    ram1[3] = 32'h0B0D_0A0D;
    run(0, 0, bc, wc, w0);
    check("multi_f0", ram2[0], pk(2, 2, 6));
    check("multi_f1", ram2[1], pk(6, 0, 2));
    check("multi_f2", ram2[2], pk(-1, 5, 11));
    check("multi_busy", 32'(bc), 32'd23);
    check("multi_writes", 32'(wc), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("multi_addr%0d", k), 32'(wr_log[(w0 + k) % 1024]), 32'(k));

    ram1[0] = 32'hFFFF_FE00;
    run(0, 0, bc, wc, w0);
    check("zero_busy", 32'(bc), 32'd2);
    check("zero_writes", 32'(wc), 32'd0);

    ram1[0] = 32'd2;
    ram1[1] = 32'h0B0D_0A0D;
    ram1[2] = 32'h0D0C_0B0A;
    run(3, 14, bc, wc, w0);
    repeat (3) @(negedge clk);
    #1;
    check("repulse_idle", 32'(bus.busy), 32'd0);
    check("repulse_busy", 32'(bc), 32'd16);
    check("repulse_writes", 32'(wc), 32'd2);
    check("repulse_f0", ram2[0], pk(-1, 5, 11));
    check("repulse_f1", ram2[1], pk(2, 2, 6));

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 256; k++) ram0[k] = $urandom;
      n = $urandom_range(4, 24);
      ram1[0] = {$urandom_range(0, 8388607), 9'(n)} ;
      exp_q.delete();
      for (int f = 1; f <= n; f++) begin
        ram1[f] = $urandom;
        exp_q.push_back(model_face(ram1[f]));
      end
      run(0, 0, bc, wc, w0);
      for (int f = 0; f < n; f++) begin
        check($sformatf("rand%0d_f%0d", r, f), ram2[f], exp_q[f]);
        check($sformatf("rand%0d_a%0d", r, f), 32'(wr_log[(w0 + f) % 1024]), 32'(f));
      end
      check($sformatf("rand%0d_busy", r), 32'(bc), 32'(2 + 7 * n));
      check($sformatf("rand%0d_writes", r), 32'(wc), 32'(n));
    end

    // Reset during V2 of face 1 (busy cycle 14), then a fresh run.
    ram1[0] = 32'd3;
    for (int f = 1; f <= 3; f++) ram1[f] = $urandom;
    exp_q.delete();
    exp_q.push_back(model_face(ram1[1]));
    @(negedge clk); #1;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    repeat (13) @(negedge clk);
    #1;
    check("mid_en0", 32'(bus.en0), 32'd1);
    check("mid_a0", 32'(bus.a0), 32'(ram1[2][23:16]));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_ctrl", 32'({bus.en0, bus.en1, bus.en2, bus.we0, bus.we1, bus.we2}), 32'd0);
    check("mid_rst_addr", 32'({bus.a0, bus.a1, bus.a2}), 32'd0);
    check("mid_rst_di2", bus.di2, 32'd0);
    check("mid_partial_f0", ram2[0], exp_q[0]);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_idle", 32'(bus.busy), 32'd0);
    for (int f = 1; f <= 3; f++) ram1[f] = $urandom;
    exp_q.delete();
    for (int f = 1; f <= 3; f++) exp_q.push_back(model_face(ram1[f]));
    run(0, 0, bc, wc, w0);
    for (int f = 0; f < 3; f++)
      check($sformatf("post_rst_f%0d", f), ram2[f], exp_q[f]);
    check("post_rst_busy", 32'(bc), 32'd23);
    check("post_rst_writes", 32'(wc), 32'd3);

    @(negedge clk); #1;
    check("bus_hygiene", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
